// File: rtl/out_port_scheduler.sv
// Round-robin egress read scheduler: grants port_rd to one non-empty port per packet,
// then enforces an inter-packet gap. Optional busy timeout enabled by SCHED_TIMEOUT_EN.
module out_port_scheduler #(
  parameter int N_PORTS        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GW             = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sched_en,
  input  logic [N_PORTS-1:0] port_empty,
  input  logic [N_PORTS-1:0] pkt_done,
  output logic [N_PORTS-1:0] port_rd,
  output logic               grant_vld,
  output logic [GW-1:0]      grant_id,
  output logic               timeout_err
);

  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t             state_reg;
  logic [GW-1:0]      rr_ptr_reg;
  logic [GCW-1:0]     gap_cnt_reg;
  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] sel_onehot;
  logic [GW-1:0]      sel_idx;
  logic [GW-1:0]      cand;
  logic               sel_vld;
  logic               done_hit;
  logic               timeout_hit;
  logic               release_now;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign req[gi]        = ~port_empty[gi];
    assign sel_onehot[gi] = (sel_idx == GW'(gi));
  end

  // Scan from farthest to nearest so the first non-empty port after rr_ptr wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      cand = GW'((int'(rr_ptr_reg) + k) % N_PORTS);
      if (req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign done_hit = pkt_done[grant_id];

`ifdef SCHED_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] busy_cnt_reg;

  assign timeout_hit = (busy_cnt_reg == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_reg <= '0;
      timeout_err  <= 1'b0;
    end else begin
      timeout_err <= release_now && !done_hit;
      if (state_reg != BUSY)
        busy_cnt_reg <= '0;
      else if (!release_now)
        busy_cnt_reg <= busy_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign release_now = (state_reg == BUSY) && (done_hit || timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= GW'(N_PORTS - 1);
      gap_cnt_reg <= '0;
      port_rd     <= '0;
      grant_vld   <= 1'b0;
      grant_id    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sched_en && sel_vld) begin
            port_rd   <= sel_onehot;
            grant_id  <= sel_idx;
            grant_vld <= 1'b1;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            port_rd     <= '0;
            grant_vld   <= 1'b0;
            rr_ptr_reg  <= grant_id;
            gap_cnt_reg <= GCW'(GAP_CYCLES - 1);
            state_reg   <= GAP;
          end
        end
        GAP: begin
          // Leave on the edge the counter reaches zero; the IDLE cycle completes the gap.
          if (gap_cnt_reg <= GCW'(1))
            state_reg <= IDLE;
          if (gap_cnt_reg != '0)
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_scheduler.sv
// Scoreboard bench for out_port_scheduler: expected grants are queued when requests
// are driven and compared when the DUT raises grant_vld.
module tb_out_port_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sched_en = 1'b1;
  logic [3:0] port_empty = 4'hF;
  logic [3:0] pkt_done = 4'h0;
  logic [3:0] port_rd;
  logic       grant_vld;
  logic [1:0] grant_id;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_ptr = 3;

  out_port_scheduler #(
    .N_PORTS(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .port_empty(port_empty),
    .pkt_done(pkt_done), .port_rd(port_rd), .grant_vld(grant_vld),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic int pick(input int ptr, input logic [3:0] emp);
    for (int k = 1; k <= 4; k++) begin
      if (!emp[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic drive_req(input logic [3:0] emp);
    port_empty = emp;
    if (pick(m_ptr, emp) >= 0) exp_q.push_back(pick(m_ptr, emp));
  endtask

  // Counts zero samples (current one included) until grant_vld, then checks the grant.
  task automatic wait_grant(input string tag, output int zeros, output int id);
    zeros = 0;
    id = 0;
    while (!grant_vld && zeros < 50) begin
      zeros++;
      @(negedge clk);
    end
    if (!grant_vld) begin
      chk({tag, "_vld"}, grant_vld, 1);
    end else if (exp_q.size() == 0) begin
      chk({tag, "_pending"}, exp_q.size(), 1);
    end else begin
      id = exp_q.pop_front();
      chk({tag, "_id"}, grant_id, id);
      chk({tag, "_rd"}, port_rd, 4'b0001 << id);
    end
  endtask

  task automatic release_port(input int id, input logic [3:0] emp_after);
    pkt_done[id] = 1'b1;
    m_ptr = id;
    port_empty = emp_after;
    if (sched_en && pick(m_ptr, emp_after) >= 0) exp_q.push_back(pick(m_ptr, emp_after));
    @(negedge clk);
    pkt_done = 4'h0;
    chk("rel_rd", port_rd, 4'h0);
  endtask

  initial begin
    int z, id, bad;
    int seq[5] = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge clk);
    chk("rst_rd", port_rd, 0);
    chk("rst_vld", grant_vld, 0);
    chk("rst_id", grant_id, 0);
    chk("rst_te", timeout_err, 0);
    rst_n = 1'b1;

    // all ports empty: no grant
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (port_rd != 0 || grant_vld) bad++;
    end
    chk("t1_idle", bad, 0);

    // full rotation with 2-cycle gaps
    drive_req(4'b0000);
    for (int g = 0; g < 5; g++) begin
      wait_grant("t2", z, id);
      chk("t2_seq", grant_id, seq[g]);
      if (g > 0) chk("t2_gap", z, 2);
      repeat (5) @(negedge clk);
      release_port(id, (g == 4) ? 4'hF : 4'h0);
    end
    repeat (5) @(negedge clk);
    chk("t2_quiet", grant_vld, 0);

    // single port, foreign pkt_done ignored
    drive_req(4'b1011);
    wait_grant("t3", z, id);
    chk("t3_lat", z, 1);
    pkt_done = 4'b0001;
    @(negedge clk);
    pkt_done = 4'h0;
    @(negedge clk);
    chk("t3_hold", port_rd, 4'b0100);
    release_port(2, 4'hF);
    chk("t3_idhold", grant_id, 2);
    repeat (4) @(negedge clk);

    // sched_en low: grant held, no arbitration after the gap
    drive_req(4'b1101);
    wait_grant("t4a", z, id);
    sched_en = 1'b0;
    port_empty = 4'b1001;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (port_rd != 4'b0010) bad++;
    end
    chk("t4_hold", bad, 0);
    release_port(1, 4'b1001);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (grant_vld) bad++;
    end
    chk("t4_noarb", bad, 0);
    sched_en = 1'b1;
    exp_q.push_back(pick(m_ptr, port_empty));
    wait_grant("t4b", z, id);
    repeat (3) @(negedge clk);
    release_port(2, 4'hF);
    repeat (4) @(negedge clk);

    // grant port 3 with no pkt_done
    drive_req(4'b0111);
    wait_grant("t5a", z, id);
    port_empty = 4'b0000;
`ifdef SCHED_TIMEOUT_EN
    bad = 0;
    while (grant_vld && bad < 100) begin
      bad++;
      @(negedge clk);
    end
    chk("t5_busy", bad, 8);
    chk("t5_te", timeout_err, 1);
    m_ptr = 3;
    exp_q.push_back(pick(m_ptr, port_empty));
    @(negedge clk);
    chk("t5_te_pulse", timeout_err, 0);
    wait_grant("t5b", z, id);
    chk("t5_gap", z, 1);
`else
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (port_rd != 4'b1000 || timeout_err) bad++;
    end
    chk("t5_hold", bad, 0);
    release_port(3, 4'h0);
    wait_grant("t5b", z, id);
    chk("t5_gap", z, 2);
`endif

    // async reset mid-packet on port 2
    repeat (2) @(negedge clk);
    release_port(0, 4'b1011);
    wait_grant("t6a", z, id);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd", port_rd, 0);
    chk("t6_vld", grant_vld, 0);
    chk("t6_id", grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_ptr = 3;
    drive_req(4'b0000);
    wait_grant("t6b", z, id);

    // pkt_done in the first BUSY cycle releases
    release_port(0, 4'hF);
    chk("t7_vld", grant_vld, 0);
    chk("q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
